// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and byte-enable patterns.
package mem_stage_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mem_state_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: byte enables and replicated store data out,
// lane-selected and sign/zero-extended load data back in.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = rdata[{addr, 3'b000} +: 8];
        half_lane  = addr[1] ? rdata[31:16] : rdata[15:0];
        be         = BE_WORD;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be        = BE_BYTE0 << addr;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
            end
            SIZE_HALF: begin
                be         = addr[1] ? BE_HI_HALF : BE_LO_HALF;
                wdata      = {2{store_data[15:0]}};
                load_data  = {{16{is_signed & half_lane[15]}}, half_lane};
                misaligned = addr[0];
            end
            // reserved size 3 behaves as a word access
            default: begin
                misaligned = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ack data-memory access with upstream stall.
// Optional ack watchdog and bus_error output when MEM_TIMEOUT_EN is defined.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MemSize_in,
    input  logic        MemSigned_in,
    input  logic        RegWrite_in,
    input  logic [4:0]  RegWriteDst_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] StoreData_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        misalign,
`ifdef MEM_TIMEOUT_EN
    output logic        bus_error,
`endif
    output logic        RegWrite,
    output logic [31:0] MEM_WB_Forward_Data,
    output logic [4:0]  RegWriteDst
);

    mem_state_t  state;
    logic [31:0] load_reg;
    logic        mem_op;
    logic        misaligned;
    logic        aborted;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    assign mem_op = valid_in & (MemRead_in | MemWrite_in);

    load_store_align u_align (
        .addr       (ALUResult_in[1:0]),
        .size       (MemSize_in),
        .is_signed  (MemSigned_in),
        .store_data (StoreData_in),
        .rdata      (dmem_rdata),
        .be         (be_next),
        .wdata      (wdata_next),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
    // bus_error is high exactly during the RESP cycle of an aborted access
    assign aborted = bus_error;
`else
    assign aborted = 1'b0;
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end
`endif

    always_comb begin
        stall               = 1'b0;
        misalign            = 1'b0;
        RegWrite            = 1'b0;
        MEM_WB_Forward_Data = ALUResult_in;
        RegWriteDst         = RegWriteDst_in;
        case (state)
            IDLE: begin
                if (!mem_op) begin
                    RegWrite = valid_in & RegWrite_in;
                end else if (misaligned) begin
                    misalign = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            ACCESS: stall = 1'b1;
            RESP: begin
                if (MemRead_in && !MemWrite_in) begin
                    RegWrite            = RegWrite_in & ~aborted;
                    MEM_WB_Forward_Data = load_reg;
                end
            end
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= BE_NONE;
            dmem_wdata <= '0;
            load_reg   <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt   <= '0;
            bus_error  <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            bus_error <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (mem_op && !misaligned) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite_in;
                        dmem_addr  <= {ALUResult_in[31:2], 2'b00};
                        dmem_be    <= be_next;
                        dmem_wdata <= wdata_next;
                        state      <= ACCESS;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        load_reg <= load_data;
                        dmem_req <= 1'b0;
                        state    <= RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        dmem_req  <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table plus delayed-ack, reset and timeout sequences.
`timescale 1ns/1ps
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, MemRead_in, MemWrite_in, MemSigned_in, RegWrite_in;
    logic [1:0]  MemSize_in;
    logic [4:0]  RegWriteDst_in;
    logic [31:0] ALUResult_in, StoreData_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall, misalign, RegWrite;
    logic [31:0] MEM_WB_Forward_Data;
    logic [4:0]  RegWriteDst;
`ifdef MEM_TIMEOUT_EN
    logic        bus_error;
    localparam int DELAY = 3;
`else
    localparam int DELAY = 5;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .valid_in            (valid_in),
        .MemRead_in          (MemRead_in),
        .MemWrite_in         (MemWrite_in),
        .MemSize_in          (MemSize_in),
        .MemSigned_in        (MemSigned_in),
        .RegWrite_in         (RegWrite_in),
        .RegWriteDst_in      (RegWriteDst_in),
        .ALUResult_in        (ALUResult_in),
        .StoreData_in        (StoreData_in),
        .dmem_req            (dmem_req),
        .dmem_we             (dmem_we),
        .dmem_addr           (dmem_addr),
        .dmem_be             (dmem_be),
        .dmem_wdata          (dmem_wdata),
        .dmem_rdata          (dmem_rdata),
        .dmem_ack            (dmem_ack),
        .stall               (stall),
        .misalign            (misalign),
`ifdef MEM_TIMEOUT_EN
        .bus_error           (bus_error),
`endif
        .RegWrite            (RegWrite),
        .MEM_WB_Forward_Data (MEM_WB_Forward_Data),
        .RegWriteDst         (RegWriteDst)
    );

    typedef struct {
        logic        valid, rd, wr, sgn, rw;
        logic [1:0]  size;
        logic [4:0]  dst;
        logic [31:0] alu, sd, rdata;
        logic        e_acc, e_mis, e_we, e_rw;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata, e_data;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, rd, wr, input logic [1:0] size, input logic sgn, rw,
                         input logic [4:0] dst, input logic [31:0] alu, sd);
        valid_in = valid; MemRead_in = rd; MemWrite_in = wr; MemSize_in = size;
        MemSigned_in = sgn; RegWrite_in = rw; RegWriteDst_in = dst;
        ALUResult_in = alu; StoreData_in = sd;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        drive(v.valid, v.rd, v.wr, v.size, v.sgn, v.rw, v.dst, v.alu, v.sd);
        @(negedge clk);
        chk($sformatf("v%0d_idle_stall", idx), 32'(stall), 32'(v.e_acc));
        chk($sformatf("v%0d_idle_misalign", idx), 32'(misalign), 32'(v.e_mis));
        chk($sformatf("v%0d_idle_req", idx), 32'(dmem_req), 32'd0);
        if (!v.e_acc) begin
            chk($sformatf("v%0d_rw", idx), 32'(RegWrite), 32'(v.e_rw));
            if (v.e_rw) chk($sformatf("v%0d_data", idx), MEM_WB_Forward_Data, v.e_data);
            chk($sformatf("v%0d_dst", idx), 32'(RegWriteDst), 32'(v.dst));
        end else begin
            chk($sformatf("v%0d_idle_rw", idx), 32'(RegWrite), 32'd0);
            next_cycle();
            dmem_ack = 1'b1; dmem_rdata = v.rdata;
            @(negedge clk);
            chk($sformatf("v%0d_acc_req", idx), 32'(dmem_req), 32'd1);
            chk($sformatf("v%0d_acc_stall", idx), 32'(stall), 32'd1);
            chk($sformatf("v%0d_acc_we", idx), 32'(dmem_we), 32'(v.e_we));
            chk($sformatf("v%0d_acc_addr", idx), dmem_addr, v.e_addr);
            chk($sformatf("v%0d_acc_be", idx), 32'(dmem_be), 32'(v.e_be));
            if (v.e_we) chk($sformatf("v%0d_acc_wdata", idx), dmem_wdata, v.e_wdata);
            next_cycle();
            dmem_ack = 1'b0; dmem_rdata = 32'h0;
            @(negedge clk);
            chk($sformatf("v%0d_resp_req", idx), 32'(dmem_req), 32'd0);
            chk($sformatf("v%0d_resp_stall", idx), 32'(stall), 32'd0);
            chk($sformatf("v%0d_resp_rw", idx), 32'(RegWrite), 32'(v.e_rw));
            if (v.e_rw) chk($sformatf("v%0d_resp_data", idx), MEM_WB_Forward_Data, v.e_data);
            chk($sformatf("v%0d_resp_dst", idx), 32'(RegWriteDst), 32'(v.dst));
        end
        next_cycle();
        valid_in = 1'b0;
    endtask

    initial begin
        //            valid rd wr sgn rw size  dst   alu           sd            rdata         acc mis we rw  be       addr          wdata         data
        vecs[0]  = '{1, 0, 0, 0, 1, 2'd2, 5'd5,  32'h0000_1234, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'h0,        32'h0000_1234};
        vecs[1]  = '{1, 1, 0, 0, 1, 2'd2, 5'd6,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 0, 0, 1, 4'b1111, 32'h0000_0100, 32'h0,       32'hDEAD_BEEF};
        vecs[2]  = '{1, 1, 0, 1, 1, 2'd0, 5'd7,  32'h0000_0103, 32'h0,        32'h8011_2233, 1, 0, 0, 1, 4'b1000, 32'h0000_0100, 32'h0,       32'hFFFF_FF80};
        vecs[3]  = '{1, 1, 0, 0, 1, 2'd0, 5'd7,  32'h0000_0103, 32'h0,        32'h8011_2233, 1, 0, 0, 1, 4'b1000, 32'h0000_0100, 32'h0,       32'h0000_0080};
        vecs[4]  = '{1, 0, 1, 0, 0, 2'd1, 5'd0,  32'h0000_0102, 32'hABCD_1234, 32'h0,       1, 0, 1, 0, 4'b1100, 32'h0000_0100, 32'h1234_1234, 32'h0};
        vecs[5]  = '{1, 1, 0, 0, 1, 2'd2, 5'd8,  32'h0000_0101, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[6]  = '{1, 1, 0, 1, 1, 2'd1, 5'd9,  32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 0, 0, 1, 4'b1100, 32'h0000_0100, 32'h0,       32'hFFFF_8001};
        vecs[7]  = '{1, 1, 0, 1, 1, 2'd1, 5'd10, 32'h0000_0100, 32'h0,        32'h1234_F00D, 1, 0, 0, 1, 4'b0011, 32'h0000_0100, 32'h0,       32'hFFFF_F00D};
        vecs[8]  = '{1, 0, 1, 0, 0, 2'd0, 5'd0,  32'h0000_0101, 32'h0000_00A5, 32'h0,       1, 0, 1, 0, 4'b0010, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0};
        vecs[9]  = '{1, 0, 1, 0, 0, 2'd2, 5'd0,  32'h0000_0204, 32'hCAFE_F00D, 32'h0,       1, 0, 1, 0, 4'b1111, 32'h0000_0204, 32'hCAFE_F00D, 32'h0};
        vecs[10] = '{1, 1, 0, 1, 1, 2'd1, 5'd11, 32'h0000_0103, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[11] = '{1, 1, 0, 0, 1, 2'd3, 5'd12, 32'h0000_010C, 32'h0,        32'h0102_0304, 1, 0, 0, 1, 4'b1111, 32'h0000_010C, 32'h0,       32'h0102_0304};
        vecs[12] = '{0, 1, 0, 0, 1, 2'd2, 5'd13, 32'h0000_0777, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[13] = '{1, 1, 0, 0, 1, 2'd0, 5'd14, 32'h0000_0100, 32'h0,        32'h8011_2233, 1, 0, 0, 1, 4'b0001, 32'h0000_0100, 32'h0,       32'h0000_0033};
        vecs[14] = '{1, 1, 0, 1, 1, 2'd0, 5'd15, 32'h0000_0102, 32'h0,        32'h8011_2233, 1, 0, 0, 1, 4'b0100, 32'h0000_0100, 32'h0,       32'h0000_0011};

        reset = 1'b0;
        drive(0, 0, 0, 2'd0, 0, 0, 5'd0, 32'h0, 32'h0);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(posedge clk); @(negedge clk);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        next_cycle();
        reset = 1'b1;

        for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);

        // delayed ack; ack held during IDLE must be ignored
        drive(1, 1, 0, 2'd2, 0, 1, 5'd9, 32'h0000_0300, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("dly_idle_stall", 32'(stall), 32'd1);
        next_cycle();
        dmem_ack = 1'b0;
        for (int i = 0; i < DELAY; i++) begin
            @(negedge clk);
            chk($sformatf("dly_wait%0d_req", i), 32'(dmem_req), 32'd1);
            chk($sformatf("dly_wait%0d_stall", i), 32'(stall), 32'd1);
            next_cycle();
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h1357_2468;
        @(negedge clk);
        chk("dly_ack_req", 32'(dmem_req), 32'd1);
        next_cycle();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("dly_resp_stall", 32'(stall), 32'd0);
        chk("dly_resp_rw", 32'(RegWrite), 32'd1);
        chk("dly_resp_data", MEM_WB_Forward_Data, 32'h1357_2468);
        next_cycle();
        valid_in = 1'b0;

        // reset asserted mid-access
        drive(1, 1, 0, 2'd2, 0, 1, 5'd3, 32'h0000_0400, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rstmid_acc_req", 32'(dmem_req), 32'd1);
        next_cycle();
        @(negedge clk);
        #2;
        reset = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("rstmid_req", 32'(dmem_req), 32'd0);
        chk("rstmid_stall_idle", 32'(stall), 32'd0);
        chk("rstmid_be", 32'(dmem_be), 32'd0);
        chk("rstmid_addr", dmem_addr, 32'h0);
        next_cycle();
        reset = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("rstmid_after_req", 32'(dmem_req), 32'd0);
        chk("rstmid_after_stall", 32'(stall), 32'd0);
        next_cycle();
        dmem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
        drive(1, 1, 0, 2'd2, 0, 1, 5'd4, 32'h0000_0500, 32'h0);
        @(negedge clk);
        chk("to_idle_stall", 32'(stall), 32'd1);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d_req", i), 32'(dmem_req), 32'd1);
            chk($sformatf("to_wait%0d_berr", i), 32'(bus_error), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("to_resp_berr", 32'(bus_error), 32'd1);
        chk("to_resp_rw", 32'(RegWrite), 32'd0);
        chk("to_resp_stall", 32'(stall), 32'd0);
        chk("to_resp_req", 32'(dmem_req), 32'd0);
        next_cycle();
        valid_in = 1'b0;
        @(negedge clk);
        chk("to_after_berr", 32'(bus_error), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage; sits directly upstream of the MEM/WB register and drives its RegWrite_in, MEM_WB_Forward_Data_in and RegWriteDst_in inputs.
- Takes EX/MEM results and performs load/store accesses on a req/ack data-memory port.
- Handles byte/halfword lane steering and sign/zero extension.
- Stalls the upstream pipeline while an access is outstanding.
- Non-memory ops pass through combinationally.

Parameters:
- TIMEOUT_CYCLES, 16, ack watchdog limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset: asserted when 0, acts immediately, released synchronously by the environment.
- valid_in  in  1  EX/MEM holds a valid instruction.
- MemRead_in  in  1  load.
- MemWrite_in  in  1  store.
- MemSize_in  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word).
- MemSigned_in  in  1  sign-extend load data.
- RegWrite_in  in  1  instruction writes a register.
- RegWriteDst_in  in  5  destination register.
- ALUResult_in  in  32  ALU result / effective address.
- StoreData_in  in  32  store source, value in low bits.
- dmem_req  out  1  access request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address, bits [1:0]=0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  access complete.
- stall  out  1  upstream must hold EX/MEM contents.
- misalign  out  1  one-cycle pulse: misaligned access dropped.
- RegWrite  out  1  to MEM/WB RegWrite_in.
- MEM_WB_Forward_Data  out  32  to MEM/WB data input.
- RegWriteDst  out  5  to MEM/WB RegWriteDst_in.

Behaviour:
- mem_op = valid_in & (MemRead_in | MemWrite_in).
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- FSM states: IDLE, ACCESS, RESP.
- Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, load register=0, misalign=0.
  - stall, RegWrite, RegWriteDst and MEM_WB_Forward_Data then evaluate from IDLE: non-mem ops pass through, mem ops stall.
- IDLE, no mem_op:
  - RegWrite = valid_in & RegWrite_in; data = ALUResult_in; dst = RegWriteDst_in.
  - stall=0; zero added latency.
- IDLE, mem_op, misaligned:
  - No access; misalign=1 for this cycle; RegWrite=0; stall=0. The instruction retires as a bubble.
- IDLE, mem_op, aligned:
  - stall=1; RegWrite=0.
  - Register dmem_addr={addr[31:2],2'b00}, dmem_we=MemWrite_in, dmem_be and dmem_wdata; go to ACCESS.
- dmem_be by size:
  - byte: 1<<addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- dmem_wdata: byte replicated ×4, half ×2, word as-is.
- ACCESS:
  - dmem_req=1; stall=1; RegWrite=0.
  - Request fields stay stable until ack.
  - On dmem_ack: capture the formatted dmem_rdata into the load register, drop dmem_req next cycle, go to RESP.
- RESP:
  - stall=0.
  - Load: RegWrite=RegWrite_in, data=load register.
  - Store: RegWrite=0.
  - dst=RegWriteDst_in. Next state IDLE.
- Load formatting:
  - Select lane by addr[1:0] (byte) or addr[1] (half).
  - Zero-extend, or sign-extend when MemSigned_in=1.
- Minimum memory-op occupancy is 3 cycles: IDLE, 1 ACCESS cycle, RESP. Each extra ack-wait cycle adds 1.
- Upstream guarantees: inputs stay stable while stall=1; the next instruction is presented only after RESP.
- dmem_ack outside ACCESS is ignored.
- Reset mid-access: state returns to IDLE at once, dmem_req drops asynchronously, and the outstanding request is abandoned.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle without ack.
  - At TIMEOUT_CYCLES the access is aborted: state goes to RESP with RegWrite forced 0, and output bus_error (1 bit) pulses for one cycle.
  - Ack and timeout in the same cycle: ack wins.
- Undefined: no counter and no bus_error port; ACCESS waits indefinitely.

Decomposition:
- Package mem_stage_pkg:
  - MemSize encoding constants (SIZE_BYTE/HALF/WORD).
  - FSM state enum.
  - Byte-enable constants.
- Sub-module load_store_align (combinational): address, size and signedness in → be, wdata, formatted load data out.

Test Plan:
- ALU op, ALUResult_in=0x1234, RegWrite_in=1, dst=5 → same cycle: RegWrite=1, data=0x1234, dst=5, stall=0, dmem_req=0.
- LW addr 0x100, ack in first ACCESS cycle, rdata=0xDEADBEEF → stall high 2 cycles; RESP: data=0xDEADBEEF, RegWrite=1.
- LB signed addr 0x103, rdata=0x80112233 → be=4'b1000 during access; data=0xFFFFFF80. Same access unsigned → 0x00000080.
- SH addr 0x102, StoreData_in=0xABCD1234 → dmem_we=1, be=4'b1100, wdata=0x12341234, RegWrite=0 in RESP.
- LW addr 0x101 → misalign pulse, no dmem_req, stall=0, RegWrite=0.
- Ack delayed 5 cycles, then reset driven low during ACCESS → dmem_req=0 immediately, state IDLE. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → bus_error pulse after 4 ACCESS cycles, RegWrite=0.
